// File: rtl/bpsk_ctrl_pkg.sv
// Shared types and default constants for the BPSK acquisition/tracking sequencer.
package bpsk_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned SEED_W   = 8;
  localparam int unsigned SETTLE_W = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned EDGE_W   = 16;
  localparam int unsigned WIN_W    = 32;
  localparam int unsigned RATE_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_TRACK  = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam logic [SEED_W-1:0]   DEF_F_MIN        = 8'd10;
  localparam logic [SEED_W-1:0]   DEF_F_MAX        = 8'd100;
  localparam logic [SEED_W-1:0]   DEF_F_STEP       = 8'd2;
  localparam logic [SETTLE_W-1:0] DEF_SETTLE_TICKS = 16'd500;
  localparam logic [CNT_W-1:0]    DEF_LOCK_HOLD    = 8'd32;
  localparam logic [CNT_W-1:0]    DEF_LOSS_TICKS   = 8'd16;
  localparam logic [WIN_W-1:0]    DEF_MEAS_WIN     = 32'd50_000_000;

endpackage

// File: rtl/edge_rate_meter.sv
// Counts transitions of din over fixed windows of MEAS_WIN clocks while run is high;
// rate holds the saturated count of the last completed window.
module edge_rate_meter
  import bpsk_ctrl_pkg::*;
#(
  parameter logic [WIN_W-1:0] MEAS_WIN = DEF_MEAS_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              din,
  output logic [RATE_W-1:0] rate
);

  logic [1:0]        sync_q, sync_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              edge_c;

  always_comb begin
    sync_d     = {sync_q[0], din};
    edge_c     = sync_q[0] ^ sync_q[1];
    edge_cnt_d = edge_cnt_q;
    win_cnt_d  = win_cnt_q;
    rate_d     = rate_q;
    if (!run) begin
      edge_cnt_d = '0;
      win_cnt_d  = '0;
    end else if (win_cnt_q >= MEAS_WIN - 32'd1) begin
      // An edge seen on the closing cycle belongs to the next window.
      rate_d     = (edge_cnt_q > 16'd255) ? 8'd255 : edge_cnt_q[RATE_W-1:0];
      edge_cnt_d = EDGE_W'(edge_c);
      win_cnt_d  = '0;
    end else begin
      win_cnt_d = win_cnt_q + 32'd1;
      if (edge_c && (edge_cnt_q != 16'hFFFF)) begin
        edge_cnt_d = edge_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      edge_cnt_q <= '0;
      win_cnt_q  <= '0;
      rate_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      edge_cnt_q <= edge_cnt_d;
      win_cnt_q  <= win_cnt_d;
      rate_q     <= rate_d;
    end
  end

  assign rate = rate_q;

endmodule

// File: rtl/bpsk_acq_ctrl.sv
// Acquisition/tracking sequencer: sweeps the VCO seed until the Costas loop holds lock,
// supervises lock in TRACK, re-acquires on loss and reports the symbol-transition rate.
module bpsk_acq_ctrl
  import bpsk_ctrl_pkg::*;
#(
  parameter logic [SEED_W-1:0]   F_MIN        = DEF_F_MIN,
  parameter logic [SEED_W-1:0]   F_MAX        = DEF_F_MAX,
  parameter logic [SEED_W-1:0]   F_STEP       = DEF_F_STEP,
  parameter logic [SETTLE_W-1:0] SETTLE_TICKS = DEF_SETTLE_TICKS,
  parameter logic [CNT_W-1:0]    LOCK_HOLD    = DEF_LOCK_HOLD,
  parameter logic [CNT_W-1:0]    LOSS_TICKS   = DEF_LOSS_TICKS,
  parameter logic [WIN_W-1:0]    MEAS_WIN     = DEF_MEAS_WIN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               tick,
  input  logic               lock,
  input  logic               data_sign,
  output logic               dp_en,
  output logic [SEED_W-1:0]  vco_seed,
  output logic               locked,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [RATE_W-1:0]  freq
);

  state_e              st_q, st_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  logic                dp_en_q, dp_en_d;
  logic                locked_q, locked_d;
  logic                fail_q, fail_d;
  logic [SEED_W:0]     seed_next_c;

  always_comb begin
    st_d        = st_q;
    seed_d      = seed_q;
    settle_d    = settle_q;
    hold_d      = hold_q;
    loss_d      = loss_q;
    seed_next_c = (SEED_W+1)'(seed_q) + (SEED_W+1)'(F_STEP);

    if (abort) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE, ST_FAIL: begin
          if (start) begin
            st_d     = ST_SETTLE;
            seed_d   = F_MIN;
            settle_d = '0;
            hold_d   = '0;
            loss_d   = '0;
          end
        end
        ST_SETTLE: begin
          if (tick) begin
            if (settle_q + 16'd1 >= SETTLE_TICKS) begin
              st_d     = ST_CHECK;
              settle_d = '0;
              hold_d   = '0;
            end else begin
              settle_d = settle_q + 16'd1;
            end
          end
        end
        ST_CHECK: begin
          // One attempt per seed: any unlocked tick ends it.
          if (tick) begin
            if (lock) begin
              if (hold_q + 8'd1 >= LOCK_HOLD) begin
                st_d   = ST_TRACK;
                hold_d = '0;
                loss_d = '0;
              end else begin
                hold_d = hold_q + 8'd1;
              end
            end else if (seed_next_c > (SEED_W+1)'(F_MAX)) begin
              st_d   = ST_FAIL;
              hold_d = '0;
            end else begin
              st_d     = ST_SETTLE;
              seed_d   = seed_next_c[SEED_W-1:0];
              settle_d = '0;
              hold_d   = '0;
            end
          end
        end
        ST_TRACK: begin
          if (tick) begin
            if (lock) begin
              loss_d = '0;
            end else if (loss_q + 8'd1 >= LOSS_TICKS) begin
              st_d     = ST_SETTLE;
              loss_d   = '0;
              settle_d = '0;
              hold_d   = '0;
            end else begin
              loss_d = loss_q + 8'd1;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end

    dp_en_d  = (st_d == ST_SETTLE) || (st_d == ST_CHECK) || (st_d == ST_TRACK);
    locked_d = (st_d == ST_TRACK);
    fail_d   = (st_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      seed_q   <= F_MIN;
      settle_q <= '0;
      hold_q   <= '0;
      loss_q   <= '0;
      dp_en_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      seed_q   <= seed_d;
      settle_q <= settle_d;
      hold_q   <= hold_d;
      loss_q   <= loss_d;
      dp_en_q  <= dp_en_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  edge_rate_meter #(
    .MEAS_WIN(MEAS_WIN)
  ) u_rate (
    .clk (clk),
    .rst (rst),
    .run (locked_q),
    .din (data_sign),
    .rate(freq)
  );

  assign dp_en    = dp_en_q;
  assign vco_seed = seed_q;
  assign locked   = locked_q;
  assign fail     = fail_q;
  assign state    = STATE_W'(st_q);

endmodule
